// File: rtl/hu_audioenc_pkg.sv
// Shared types and constants for the audio-encoder DMA scheduler.
// FSM encoding, DMA word size and debug word layout.
package hu_audioenc_pkg;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_RD_REQ  = 4'd1,
    S_RD_DATA = 4'd2,
    S_WR_REQ  = 4'd3,
    S_WR_DATA = 4'd4,
    S_DONE    = 4'd5
  } state_e;

  localparam logic [2:0] DMA_SIZE_WORD = 3'b010;

  localparam int unsigned DBG_STATE_LSB = 28;
  localparam int unsigned DBG_ERR_BIT   = 27;
  localparam int unsigned DBG_K_LSB     = 0;

  function automatic logic [31:0] dbg_word(
    input state_e      s,
    input logic        err,
    input logic [15:0] k
  );
    logic [31:0] w;
    w = '0;
    w[DBG_STATE_LSB +: 4] = s;
    w[DBG_ERR_BIT] = err;
    w[DBG_K_LSB +: 16] = k;
    return w;
  endfunction

endpackage

// File: rtl/hu_audioenc_chunk_buf.sv
// Chunk buffer: DEPTH x 32, one synchronous write port,
// one combinational read port. Contents are never reset.
module hu_audioenc_chunk_buf #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = 6
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/hu_audioenc_dma_sched.sv
// Audio-encoder DMA scheduler: moves num_chunks chunks from the
// input region to the output region through a local chunk buffer.
module hu_audioenc_dma_sched
  import hu_audioenc_pkg::*;
#(
  parameter int unsigned BUF_DEPTH = 64,
  parameter logic [2:0]  DMA_SIZE  = DMA_SIZE_WORD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] conf_info_cfg_regs_0,
  input  logic [31:0] conf_info_cfg_regs_1,
  input  logic [31:0] conf_info_cfg_regs_2,
  input  logic [31:0] conf_info_cfg_regs_3,
  input  logic        conf_done,
  output logic        dma_read_ctrl_valid,
  input  logic        dma_read_ctrl_ready,
  output logic [31:0] dma_read_ctrl_data_index,
  output logic [31:0] dma_read_ctrl_data_length,
  output logic [2:0]  dma_read_ctrl_data_size,
  input  logic        dma_read_chnl_valid,
  output logic        dma_read_chnl_ready,
  input  logic [31:0] dma_read_chnl_data,
  output logic        dma_write_ctrl_valid,
  input  logic        dma_write_ctrl_ready,
  output logic [31:0] dma_write_ctrl_data_index,
  output logic [31:0] dma_write_ctrl_data_length,
  output logic [2:0]  dma_write_ctrl_data_size,
  output logic        dma_write_chnl_valid,
  input  logic        dma_write_chnl_ready,
  output logic [31:0] dma_write_chnl_data,
  output logic        acc_done,
  output logic [31:0] debug
);

  localparam int unsigned AW =
    (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned PW = $clog2(BUF_DEPTH + 1);

  state_e        state_q;
  logic [31:0]   nchk_q, len_q, inb_q, outb_q;
  logic [31:0]   k_q, off_q, debug_q;
  logic [PW-1:0] wptr_q, rptr_q;
  logic          rd_ctrl_v_q, rd_chnl_r_q;
  logic          wr_ctrl_v_q, wr_chnl_v_q;
  logic          acc_done_q, err_q;
  logic [31:0]   buf_rdata;
  logic          buf_we, rd_last, wr_last;
  logic          cfg_big, cfg_bad;

  assign cfg_big = conf_info_cfg_regs_1 > 32'(BUF_DEPTH);
  assign cfg_bad = (conf_info_cfg_regs_0 == '0)
                || (conf_info_cfg_regs_1 == '0) || cfg_big;

  assign rd_last = 32'(wptr_q) == len_q - 32'd1;
  assign wr_last = 32'(rptr_q) == len_q - 32'd1;
  assign buf_we  = rd_chnl_r_q & dma_read_chnl_valid;

  hu_audioenc_chunk_buf #(
    .DEPTH (BUF_DEPTH),
    .AW    (AW)
  ) u_buf (
    .clk_i   (clk),
    .we_i    (buf_we),
    .waddr_i (wptr_q[AW-1:0]),
    .wdata_i (dma_read_chnl_data),
    .raddr_i (rptr_q[AW-1:0]),
    .rdata_o (buf_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      nchk_q      <= '0;
      len_q       <= '0;
      inb_q       <= '0;
      outb_q      <= '0;
      k_q         <= '0;
      off_q       <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      rd_ctrl_v_q <= 1'b0;
      rd_chnl_r_q <= 1'b0;
      wr_ctrl_v_q <= 1'b0;
      wr_chnl_v_q <= 1'b0;
      acc_done_q  <= 1'b0;
      err_q       <= 1'b0;
      debug_q     <= '0;
    end else begin
      acc_done_q <= 1'b0;
      debug_q    <= dbg_word(state_q, err_q, k_q[15:0]);
      unique case (state_q)
        S_IDLE: if (conf_done) begin
          nchk_q <= conf_info_cfg_regs_0;
          len_q  <= conf_info_cfg_regs_1;
          inb_q  <= conf_info_cfg_regs_2;
          outb_q <= conf_info_cfg_regs_3;
          k_q    <= '0;
          off_q  <= '0;
          err_q  <= cfg_big;
          if (cfg_bad) begin
            state_q    <= S_DONE;
            acc_done_q <= 1'b1;
          end else begin
            state_q     <= S_RD_REQ;
            rd_ctrl_v_q <= 1'b1;
          end
        end
        S_RD_REQ: if (dma_read_ctrl_ready) begin
          rd_ctrl_v_q <= 1'b0;
          rd_chnl_r_q <= 1'b1;
          wptr_q      <= '0;
          state_q     <= S_RD_DATA;
        end
        S_RD_DATA: if (dma_read_chnl_valid) begin
          wptr_q <= wptr_q + PW'(1);
          if (rd_last) begin
            rd_chnl_r_q <= 1'b0;
            wr_ctrl_v_q <= 1'b1;
            state_q     <= S_WR_REQ;
          end
        end
        S_WR_REQ: if (dma_write_ctrl_ready) begin
          wr_ctrl_v_q <= 1'b0;
          wr_chnl_v_q <= 1'b1;
          rptr_q      <= '0;
          state_q     <= S_WR_DATA;
        end
        S_WR_DATA: if (dma_write_chnl_ready) begin
          rptr_q <= rptr_q + PW'(1);
          if (wr_last) begin
            wr_chnl_v_q <= 1'b0;
            k_q         <= k_q + 32'd1;
            // running offset replaces k*chunk_len
            off_q       <= off_q + len_q;
            if (k_q + 32'd1 != nchk_q) begin
              state_q     <= S_RD_REQ;
              rd_ctrl_v_q <= 1'b1;
            end else begin
              state_q    <= S_DONE;
              acc_done_q <= 1'b1;
            end
          end
        end
        S_DONE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign dma_read_ctrl_valid        = rd_ctrl_v_q;
  assign dma_read_ctrl_data_index   = inb_q + off_q;
  assign dma_read_ctrl_data_length  = len_q;
  assign dma_read_ctrl_data_size    = DMA_SIZE;
  assign dma_read_chnl_ready        = rd_chnl_r_q;
  assign dma_write_ctrl_valid       = wr_ctrl_v_q;
  assign dma_write_ctrl_data_index  = outb_q + off_q;
  assign dma_write_ctrl_data_length = len_q;
  assign dma_write_ctrl_data_size   = DMA_SIZE;
  assign dma_write_chnl_valid       = wr_chnl_v_q;
  assign dma_write_chnl_data        = wr_chnl_v_q ? buf_rdata : '0;
  assign acc_done                   = acc_done_q;
  assign debug                      = debug_q;

endmodule

// File: tb/tb_hu_audioenc_dma_sched.sv
// Bench for hu_audioenc_dma_sched: random DMA stalls against a
// memory-side model of the expected request and data streams.
module tb_hu_audioenc_dma_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] cfg0 = '0, cfg1 = '0, cfg2 = '0, cfg3 = '0;
  logic        conf_done = 1'b0;
  logic        rc_valid, rc_ready = 1'b0;
  logic [31:0] rc_index, rc_length;
  logic [2:0]  rc_size;
  logic        rd_valid = 1'b0, rd_ready;
  logic [31:0] rd_data = '0;
  logic        wc_valid, wc_ready = 1'b0;
  logic [31:0] wc_index, wc_length;
  logic [2:0]  wc_size;
  logic        wd_valid, wd_ready = 1'b0;
  logic [31:0] wd_data;
  logic        acc_done;
  logic [31:0] debug;

  int nvec = 0;
  int nerr = 0;

  logic [31:0] rd_idx_q[$], rd_len_q[$], wr_idx_q[$], wr_len_q[$];
  logic [31:0] sent_q[$], got_q[$];
  int done_cnt, done_cyc, valid_seen, stab_err;
  bit timeout;

  always #5 clk = ~clk;

  hu_audioenc_dma_sched dut (
    .clk                        (clk),
    .rst                        (rst),
    .conf_info_cfg_regs_0       (cfg0),
    .conf_info_cfg_regs_1       (cfg1),
    .conf_info_cfg_regs_2       (cfg2),
    .conf_info_cfg_regs_3       (cfg3),
    .conf_done                  (conf_done),
    .dma_read_ctrl_valid        (rc_valid),
    .dma_read_ctrl_ready        (rc_ready),
    .dma_read_ctrl_data_index   (rc_index),
    .dma_read_ctrl_data_length  (rc_length),
    .dma_read_ctrl_data_size    (rc_size),
    .dma_read_chnl_valid        (rd_valid),
    .dma_read_chnl_ready        (rd_ready),
    .dma_read_chnl_data         (rd_data),
    .dma_write_ctrl_valid       (wc_valid),
    .dma_write_ctrl_ready       (wc_ready),
    .dma_write_ctrl_data_index  (wc_index),
    .dma_write_ctrl_data_length (wc_length),
    .dma_write_ctrl_data_size   (wc_size),
    .dma_write_chnl_valid       (wd_valid),
    .dma_write_chnl_ready       (wd_ready),
    .dma_write_chnl_data        (wd_data),
    .acc_done                   (acc_done),
    .debug                      (debug)
  );

  task automatic idle_inputs();
    conf_done = 1'b0;
    rc_ready  = 1'b0;
    rd_valid  = 1'b0;
    wc_ready  = 1'b0;
    wd_ready  = 1'b0;
  endtask

  // Plays the memory side of one run; records every accepted request
  // and beat. abort_beat>0 drops rst just before that read beat lands.
  task automatic run_xfer(input logic [31:0] n, len, inb, outb,
                          input bit stall, input int abort_beat);
    int cyc, nbeat, rcw, rdw, wcw, wdw;
    bit rp, wp, racc;
    logic [31:0] rpi, rpl, wpi, wpl;
    rd_idx_q.delete(); rd_len_q.delete();
    wr_idx_q.delete(); wr_len_q.delete();
    sent_q.delete(); got_q.delete();
    done_cnt = 0; done_cyc = -1; valid_seen = 0;
    stab_err = 0; timeout = 0;
    cyc = 0; nbeat = 0; rcw = 0; rdw = 0; wcw = 0; wdw = 0;
    rp = 0; wp = 0; racc = 0;
    rpi = '0; rpl = '0; wpi = '0; wpl = '0;
    idle_inputs();
    cfg0 = n; cfg1 = len; cfg2 = inb; cfg3 = outb;
    conf_done = 1'b1;
    while (cyc < 4000) begin
      @(posedge clk); #1;
      conf_done = 1'b0;
      cyc++;
      if (acc_done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (rc_valid | rd_ready | wc_valid | wd_valid) valid_seen++;
      if (rp && (!rc_valid || rc_index != rpi || rc_length != rpl))
        stab_err++;
      if (wp && (!wc_valid || wc_index != wpi || wc_length != wpl))
        stab_err++;
      rc_ready = (rcw == 0);
      if (rc_valid && rc_ready) begin
        rd_idx_q.push_back(rc_index);
        rd_len_q.push_back(rc_length);
        rp = 0;
        rcw = stall ? $urandom_range(0, 5) : 0;
      end else begin
        rp = rc_valid; rpi = rc_index; rpl = rc_length;
        if (rc_valid && rcw > 0) rcw--;
      end
      if (racc) begin
        rd_valid = 1'b0;
        racc = 0;
        rdw = stall ? $urandom_range(0, 5) : 0;
      end
      if (!rd_valid) begin
        if (rdw == 0) begin
          rd_valid = 1'b1;
          rd_data = $urandom;
        end else rdw--;
      end
      if (rd_valid && rd_ready) begin
        sent_q.push_back(rd_data);
        racc = 1;
        nbeat++;
        if (abort_beat != 0 && nbeat == abort_beat) begin
          rst = 1'b0;
          return;
        end
      end
      wc_ready = (wcw == 0);
      if (wc_valid && wc_ready) begin
        wr_idx_q.push_back(wc_index);
        wr_len_q.push_back(wc_length);
        wp = 0;
        wcw = stall ? $urandom_range(0, 5) : 0;
      end else begin
        wp = wc_valid; wpi = wc_index; wpl = wc_length;
        if (wc_valid && wcw > 0) wcw--;
      end
      wd_ready = (wdw == 0);
      if (wd_valid && wd_ready) begin
        got_q.push_back(wd_data);
        wdw = stall ? $urandom_range(0, 5) : 0;
      end else if (wd_valid && wdw > 0) wdw--;
      if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
    end
    if (done_cyc < 0) timeout = 1;
    idle_inputs();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    nvec++;
    if ({rc_valid, rd_ready, wc_valid, wd_valid, acc_done} !== 5'b0) begin
      nerr++;
      $display("FAIL reset_valids got %b want 00000",
               {rc_valid, rd_ready, wc_valid, wd_valid, acc_done});
    end
    nvec++;
    if (debug !== 32'h0) begin
      nerr++;
      $display("FAIL reset_debug got %h want 00000000", debug);
    end
    nvec++;
    if (rc_size !== 3'b010 || wc_size !== 3'b010) begin
      nerr++;
      $display("FAIL reset_size got %b/%b want 010/010", rc_size, wc_size);
    end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [31:0] e;
    run_xfer(32'd2, 32'd4, 32'h100, 32'h200, 1'b0, 0);
    nvec++;
    if (timeout !== 1'b0 || done_cnt !== 1) begin
      nerr++;
      $display("FAIL basic_done got to=%0d cnt=%0d want to=0 cnt=1",
               timeout, done_cnt);
    end
    nvec++;
    if (rd_idx_q.size() !== 2 || wr_idx_q.size() !== 2) begin
      nerr++;
      $display("FAIL basic_nreq got %0d/%0d want 2/2",
               rd_idx_q.size(), wr_idx_q.size());
    end
    for (int i = 0; i < 2; i++) begin
      e = 32'h100 + 32'(i) * 32'd4;
      nvec++;
      if (i >= rd_idx_q.size() || rd_idx_q[i] !== e || rd_len_q[i] !== 4) begin
        nerr++;
        $display("FAIL basic_rdreq%0d got %h want %h/4", i,
                 (i < rd_idx_q.size()) ? rd_idx_q[i] : 32'hx, e);
      end
      e = 32'h200 + 32'(i) * 32'd4;
      nvec++;
      if (i >= wr_idx_q.size() || wr_idx_q[i] !== e || wr_len_q[i] !== 4) begin
        nerr++;
        $display("FAIL basic_wrreq%0d got %h want %h/4", i,
                 (i < wr_idx_q.size()) ? wr_idx_q[i] : 32'hx, e);
      end
    end
    nvec++;
    if (got_q.size() !== 8 || sent_q.size() !== 8) begin
      nerr++;
      $display("FAIL basic_nbeats got %0d/%0d want 8/8",
               got_q.size(), sent_q.size());
    end
    for (int i = 0; i < got_q.size() && i < sent_q.size(); i++) begin
      nvec++;
      if (got_q[i] !== sent_q[i]) begin
        nerr++;
        $display("FAIL basic_data%0d got %h want %h", i, got_q[i], sent_q[i]);
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] n, len, inb, outb, e;
    for (int t = 0; t < 5; t++) begin
      if (t == 0) begin
        n = 2; len = 4; inb = 32'h100; outb = 32'h200;
      end else if (t == 1) begin
        n = 1; len = 64; inb = $urandom; outb = $urandom;
      end else begin
        n = $urandom_range(1, 3); len = $urandom_range(1, 16);
        inb = $urandom; outb = $urandom;
      end
      run_xfer(n, len, inb, outb, 1'b1, 0);
      nvec++;
      if (timeout !== 1'b0 || done_cnt !== 1 || stab_err !== 0) begin
        nerr++;
        $display("FAIL stall%0d_ctl got to=%0d cnt=%0d stab=%0d want 0/1/0",
                 t, timeout, done_cnt, stab_err);
      end
      nvec++;
      if (rd_idx_q.size() !== int'(n) || wr_idx_q.size() !== int'(n)) begin
        nerr++;
        $display("FAIL stall%0d_nreq got %0d/%0d want %0d", t,
                 rd_idx_q.size(), wr_idx_q.size(), n);
      end
      for (int i = 0; i < int'(n); i++) begin
        e = inb + 32'(i) * len;
        nvec++;
        if (i >= rd_idx_q.size() || rd_idx_q[i] !== e || rd_len_q[i] !== len) begin
          nerr++;
          $display("FAIL stall%0d_rdreq%0d got %h want %h", t, i,
                   (i < rd_idx_q.size()) ? rd_idx_q[i] : 32'hx, e);
        end
        e = outb + 32'(i) * len;
        nvec++;
        if (i >= wr_idx_q.size() || wr_idx_q[i] !== e || wr_len_q[i] !== len) begin
          nerr++;
          $display("FAIL stall%0d_wrreq%0d got %h want %h", t, i,
                   (i < wr_idx_q.size()) ? wr_idx_q[i] : 32'hx, e);
        end
      end
      nvec++;
      if (got_q.size() !== int'(n * len) || sent_q.size() !== int'(n * len)) begin
        nerr++;
        $display("FAIL stall%0d_nbeats got %0d/%0d want %0d", t,
                 got_q.size(), sent_q.size(), n * len);
      end
      for (int i = 0; i < got_q.size() && i < sent_q.size(); i++) begin
        nvec++;
        if (got_q[i] !== sent_q[i]) begin
          nerr++;
          $display("FAIL stall%0d_data%0d got %h want %h", t, i,
                   got_q[i], sent_q[i]);
        end
      end
    end
  endtask

  task automatic test_bad_cfg();
    logic [31:0] n, len;
    for (int t = 0; t < 3; t++) begin
      n   = (t == 1) ? 32'd0 : 32'd2;
      len = (t == 0) ? 32'd65 : ((t == 1) ? 32'd4 : 32'd0);
      run_xfer(n, len, 32'h100, 32'h200, 1'b0, 0);
      nvec++;
      if (valid_seen !== 0 || rd_idx_q.size() !== 0) begin
        nerr++;
        $display("FAIL badcfg%0d_req got %0d want 0", t, valid_seen);
      end
      nvec++;
      if (done_cyc < 1 || done_cyc > 2 || done_cnt !== 1) begin
        nerr++;
        $display("FAIL badcfg%0d_done got cyc=%0d cnt=%0d want <=2/1",
                 t, done_cyc, done_cnt);
      end
      nvec++;
      if (debug[27] !== (t == 0)) begin
        nerr++;
        $display("FAIL badcfg%0d_err got %b want %b", t, debug[27], t == 0);
      end
    end
  endtask

  task automatic test_reset_mid();
    run_xfer(32'd2, 32'd4, 32'h300, 32'h400, 1'b0, 2);
    @(posedge clk); #1;
    idle_inputs();
    nvec++;
    if ({rc_valid, rd_ready, wc_valid, wd_valid, acc_done} !== 5'b0) begin
      nerr++;
      $display("FAIL rstmid_valids got %b want 00000",
               {rc_valid, rd_ready, wc_valid, wd_valid, acc_done});
    end
    nvec++;
    if (debug !== 32'h0 || wd_data !== 32'h0 || rc_index !== 32'h0) begin
      nerr++;
      $display("FAIL rstmid_outs got %h/%h/%h want 0/0/0",
               debug, wd_data, rc_index);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    run_xfer(32'd1, 32'd3, 32'h40, 32'h80, 1'b1, 0);
    nvec++;
    if (timeout !== 1'b0 || done_cnt !== 1 || rd_idx_q.size() !== 1 ||
        rd_idx_q[0] !== 32'h40 || wr_idx_q.size() !== 1 ||
        wr_idx_q[0] !== 32'h80) begin
      nerr++;
      $display("FAIL rstmid_restart got to=%0d cnt=%0d nrd=%0d want 0/1/1",
               timeout, done_cnt, rd_idx_q.size());
    end
    nvec++;
    if (got_q.size() !== 3 || got_q != sent_q) begin
      nerr++;
      $display("FAIL rstmid_data got %0d beats want 3 matching", got_q.size());
    end
  endtask

  task automatic test_wrap();
    run_xfer(32'd2, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b1, 0);
    nvec++;
    if (rd_idx_q.size() !== 2 || rd_idx_q[1] !== 32'h0) begin
      nerr++;
      $display("FAIL wrap_rd got %h want 00000000",
               (rd_idx_q.size() > 1) ? rd_idx_q[1] : 32'hx);
    end
    nvec++;
    if (wr_idx_q.size() !== 2 || wr_idx_q[1] !== 32'h1) begin
      nerr++;
      $display("FAIL wrap_wr got %h want 00000001",
               (wr_idx_q.size() > 1) ? wr_idx_q[1] : 32'hx);
    end
    nvec++;
    if (timeout !== 1'b0 || got_q.size() !== 4 || got_q != sent_q) begin
      nerr++;
      $display("FAIL wrap_data got %0d beats to=%0d want 4 to=0",
               got_q.size(), timeout);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_bad_cfg();
    test_reset_mid();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
